mux_nto1_stream: RTL and testbench
==================================

Name: mux_nto1_stream

Overview:
- Parametrised N-input, WIDTH-bit stream multiplexer with valid/ready handshakes and one registered output stage.
- Two modes: MANUAL, where an external sel picks the channel, and ROUND-ROBIN, where it scans requesting channels fairly.
- Sits between several producer channels and a single consumer; it is the registered, multi-channel successor to the team's 1-bit 2:1 selector.

Parameters:
- WIDTH, 8, data bits per channel.
- N, 4, number of input channels (2..16).
- SELW, 2, width of sel/cur_sel; must satisfy 2**SELW >= N.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational, at most one bit set.
- sel  input  SELW  channel select in MANUAL mode.
- mode  input  1  0 = MANUAL, 1 = ROUND-ROBIN.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  output register holds data.
- out_ready  input  1  consumer accepts out_data.
- cur_sel  output  SELW  registered index of the channel currently held in out_data.

Behaviour:
- Reset (async, rst_n = 0):
  - out_valid = 0, out_data = 0, cur_sel = 0, rr_ptr = 0, in_ready = 0.
  - Reset mid-operation discards held data; nothing is replayed.
- Space condition: space = ~out_valid | out_ready.
- Grant g is combinational:
  - MANUAL: g = sel if sel < N, else no grant. If sel >= N, all in_ready = 0.
  - ROUND-ROBIN: g = first i with in_valid[i] = 1, scanning rr_ptr, rr_ptr+1, ... mod N. If no channel is valid, no grant.
- in_ready[g] = space; all other in_ready bits = 0.
- In MANUAL mode, in_ready[sel] = space regardless of in_valid[sel].
- Transfer on channel g occurs when in_valid[g] & in_ready[g]. At the next edge:
  - out_data = in_data[g], cur_sel = g, out_valid = 1.
  - In ROUND-ROBIN mode only, rr_ptr = (g+1) mod N.
- Latency: 1 cycle from input acceptance to out_valid.
- Throughput: 1 word per cycle while out_ready stays high.
- Drain: out_ready = 1 with out_valid = 1 and no new transfer -> out_valid = 0 next cycle. out_data holds its last value.
- Simultaneous drain and fill: the output register is replaced in the same edge with no bubble.
- Back-pressure: while out_valid = 1 and out_ready = 0, out_data, out_valid and cur_sel stay stable and all in_ready = 0.
- Mode and sel are sampled every cycle; a change affects only the next grant and never the held word.
- rr_ptr is retained across MANUAL periods. In MANUAL mode it does not advance.
- Wrap-around: a grant at N-1 sets rr_ptr to 0.
- Fairness: with all channels continuously valid and out_ready = 1, grants run 0,1,...,N-1,0,...
- No combinational path from out_ready to out_data.

Decomposition:
- Shared header/package holds:
  - mode constants MODE_MANUAL = 0, MODE_RR = 1;
  - a log2 helper function for SELW checking.
- One sub-module: rr_arbiter (parameter N). Inputs req[N] and ptr; outputs one-hot gnt[N], gnt_idx and any_gnt. It is purely combinational.
- The datapath mux and output register stay in mux_nto1_stream.

Test Plan:
- Reset and MANUAL select: N = 4, WIDTH = 8, reset then release; mode = 0, sel = 2, in_valid = 4'b0100, ch2 = 8'hA5, out_ready = 1 -> in_ready = 4'b0100. Next cycle out_valid = 1, out_data = 8'hA5, cur_sel = 2.
- Invalid sel: sel = 3 with N = 3, all valid -> in_ready = 0 and out_valid stays 0.
- Round-robin fairness: mode = 1, all 4 channels valid with data 8'h10..8'h13, out_ready = 1 for 8 cycles -> out_data sequence 10,11,12,13,10,11,12,13 and cur_sel 0,1,2,3,0,... every cycle with no bubbles.
- Skip and wrap-around: mode = 1, rr_ptr = 3, in_valid = 4'b0011 -> grant to ch0, then ch1, then ch0.
- Back-pressure: hold out_ready = 0 for 3 cycles with the output full -> out_data and cur_sel stable and in_ready = 0. Raise out_ready -> the held word drains and the next word loads on the same edge.
- Reset mid-stream: assert rst_n = 0 asynchronously (between edges) while out_valid = 1 -> out_valid = 0 immediately, before the next edge. After release, round-robin restarts from ch0.

Source files
------------

// File: rtl/mux_nto1_stream_pkg.sv
// Shared constants and helpers for the N:1 stream multiplexer.
// Holds the mode encoding and a log2 helper used for parameter checks.
package mux_nto1_stream_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_nto1_stream_arbiter.sv
// Combinational round-robin arbiter.
// Scans req starting at ptr, wrapping modulo N; first hit wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any_gnt
);

    int j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any_gnt && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = PW'(j);
                any_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_stream.sv
// N-input valid/ready stream mux with one registered output stage.
// MANUAL mode follows sel; ROUND-ROBIN mode rotates over valid channels.
module mux_nto1_stream
    import mux_nto1_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    cur_sel
);

    if (N < 2 || N > 16 || SELW < clog2_f(N)) begin : g_param_chk
        $error("mux_nto1_stream: bad N/SELW");
    end

    logic [SELW-1:0]  rr_ptr;
    logic [SELW-1:0]  nxt_ptr;
    logic [SELW-1:0]  rr_idx;
    logic [SELW-1:0]  g_idx;
    logic [N-1:0]     rr_gnt;
    logic [N-1:0]     sel_oh;
    logic [N-1:0]     gnt;
    logic             rr_any;
    logic             sel_ok;
    logic             space;
    logic             xfer;
    logic [WIDTH-1:0] g_data;

    rr_arbiter #(
        .N  (N),
        .PW (SELW)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any_gnt (rr_any)
    );

    // Out-of-range sel yields no grant at all.
    always_comb begin
        sel_ok = int'(sel) < N;
        sel_oh = '0;
        if (sel_ok) sel_oh[sel] = 1'b1;
        if (mode == MODE_RR) begin
            gnt   = rr_gnt;
            g_idx = rr_idx;
        end else begin
            gnt   = sel_oh;
            g_idx = sel_ok ? sel : '0;
        end
    end

    // Gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        space    = ~out_valid | out_ready;
        in_ready = gnt & {N{space & rst_n}};
        xfer     = |(in_valid & in_ready);
        g_data   = in_data[int'(g_idx)*WIDTH +: WIDTH];
        nxt_ptr  = (int'(g_idx) == N-1) ? '0 : g_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            cur_sel   <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= g_data;
            cur_sel   <= g_idx;
            if (mode == MODE_RR) rr_ptr <= nxt_ptr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Only used in RR mode; rr_any is implied by a nonzero rr_gnt.
    logic unused_ok;
    assign unused_ok = rr_any;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Self-checking bench for mux_nto1_stream against a queue-free
// behavioural model of grant, handshake and output register.
module tb_mux_nto1_stream;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic        mode;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  cur_sel;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic [1:0]  cur_sel3;

    int total;
    int bad;

    bit       m_valid;
    bit [7:0] m_data;
    int       m_sel;
    int       m_ptr;

    mux_nto1_stream #(.WIDTH(8), .N(4), .SELW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cur_sel   (cur_sel)
    );

    mux_nto1_stream #(.WIDTH(8), .N(3), .SELW(2)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .sel       (sel3),
        .mode      (1'b0),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (1'b1),
        .cur_sel   (cur_sel3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_grant();
        int j;
        if (mode == 1'b0) return int'(sel);
        for (int k = 0; k < 4; k++) begin
            j = (m_ptr + k) % 4;
            if (in_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        int g;
        bit sp;
        g  = m_grant();
        sp = !m_valid || out_ready;
        if (!rst_n || g < 0 || !sp) return 4'b0000;
        return 4'(1 << g);
    endfunction

    function automatic void m_clock();
        int g;
        bit sp;
        g  = m_grant();
        sp = !m_valid || out_ready;
        if (g >= 0 && sp && in_valid[g]) begin
            m_valid = 1'b1;
            m_data  = 8'((in_data >> (8*g)) & 32'hFF);
            m_sel   = g;
            if (mode) m_ptr = (g + 1) % 4;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        m_clock();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = 4'hF;
        in_data   = 32'h13121110;
        out_ready = 1'b1;
        in_valid3 = 3'b111;
        in_data3  = 24'h222120;
        sel3      = 2'd0;
        m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || cur_sel !== 2'd0) begin
            bad++;
            $display("FAIL reset_out: v=%b d=%h s=%0d want 0 00 0",
                     out_valid, out_data, cur_sel);
        end
        total++;
        if (in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 0000", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_manual();
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b0100;
        in_data  = 32'h00A50000;
        #1;
        total++;
        if (in_ready !== 4'b0100 || in_ready !== m_ready()) begin
            bad++;
            $display("FAIL manual_ready: got %b want 0100", in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || cur_sel !== 2'd2) begin
            bad++;
            $display("FAIL manual_out: v=%b d=%h s=%0d want 1 a5 2",
                     out_valid, out_data, cur_sel);
        end
        // ready follows sel even when that channel is idle
        in_valid = 4'b0001;
        #1;
        total++;
        if (in_ready !== 4'b0100) begin
            bad++;
            $display("FAIL manual_idle_ready: got %b want 0100", in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
            bad++;
            $display("FAIL manual_drain: v=%b d=%h want 0 a5",
                     out_valid, out_data);
        end
    endtask

    task automatic test_invalid_sel();
        sel3 = 2'd3;
        #1;
        total++;
        if (in_ready3 !== 3'b000) begin
            bad++;
            $display("FAIL badsel_ready: got %b want 000", in_ready3);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid3 !== 1'b0) begin
            bad++;
            $display("FAIL badsel_valid: got %b want 0", out_valid3);
        end
        sel3 = 2'd1;
        #1;
        total++;
        if (in_ready3 !== 3'b010) begin
            bad++;
            $display("FAIL goodsel_ready: got %b want 010", in_ready3);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid3 !== 1'b1 || out_data3 !== 8'h21 || cur_sel3 !== 2'd1) begin
            bad++;
            $display("FAIL goodsel_out: v=%b d=%h s=%0d want 1 21 1",
                     out_valid3, out_data3, cur_sel3);
        end
    endtask

    task automatic test_rr_fair();
        mode      = 1'b1;
        in_valid  = 4'hF;
        in_data   = 32'h13121110;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'(8'h10 + i % 4) ||
                cur_sel !== 2'(i % 4) || out_data !== m_data) begin
                bad++;
                $display("FAIL rr_fair[%0d]: v=%b d=%h s=%0d want 1 %h %0d",
                         i, out_valid, out_data, cur_sel, 8'h10 + i % 4, i % 4);
            end
        end
    endtask

    task automatic test_wrap();
        int exp_s[3];
        exp_s = '{0, 1, 0};
        mode     = 1'b1;
        in_valid = 4'b0100;
        tick();
        in_valid = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (cur_sel !== 2'(exp_s[i]) || out_valid !== 1'b1 ||
                out_data !== 8'(8'h10 + exp_s[i])) begin
                bad++;
                $display("FAIL rr_wrap[%0d]: s=%0d d=%h want %0d",
                         i, cur_sel, out_data, exp_s[i]);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] hd;
        logic [1:0] hs;
        mode      = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        tick();
        hd = out_data;
        hs = cur_sel;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (in_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_ready[%0d]: got %b want 0000", i, in_ready);
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== hd || cur_sel !== hs ||
                out_data !== m_data) begin
                bad++;
                $display("FAIL bp_hold[%0d]: d=%h s=%0d want %h %0d",
                         i, out_data, cur_sel, hd, hs);
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== m_ready() || in_ready === 4'b0000) begin
            bad++;
            $display("FAIL bp_release_ready: got %b want %b",
                     in_ready, m_ready());
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || cur_sel !== 2'(m_sel) ||
            out_data !== m_data || cur_sel === hs) begin
            bad++;
            $display("FAIL bp_refill: s=%0d d=%h want %0d %h",
                     cur_sel, out_data, m_sel, m_data);
        end
    endtask

    task automatic test_mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL midrst_async: v=%b rdy=%b want 0 0000",
                     out_valid, in_ready);
        end
        m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
        @(negedge clk);
        rst_n    = 1'b1;
        mode     = 1'b1;
        in_valid = 4'hF;
        tick();
        total++;
        if (cur_sel !== 2'd0 || out_data !== 8'h10 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL midrst_restart: s=%0d d=%h want 0 10",
                     cur_sel, out_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            total++;
            if (in_ready !== m_ready()) begin
                bad++;
                $display("FAIL rand_ready[%0d]: got %b want %b",
                         i, in_ready, m_ready());
            end
            tick();
            total++;
            if (out_valid !== m_valid || out_data !== m_data ||
                cur_sel !== 2'(m_sel)) begin
                bad++;
                $display("FAIL rand_out[%0d]: v=%b d=%h s=%0d want %b %h %0d",
                         i, out_valid, out_data, cur_sel,
                         m_valid, m_data, m_sel);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_manual();
        test_invalid_sel();
        test_rr_fair();
        test_wrap();
        test_back_pressure();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
